// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
//   br_entry_t   : one in-flight predicted branch {pc, predict, pred_target}
//   ctrl_state_t : controller FSM state (RUN / FLUSH)
//   OP_BRANCH    : RV32 opcode[6:2] for B-type instructions
//   DEPTH_DEF / FLUSH_CYC_DEF : default parameter values
package branch_ctrl_pkg;

    localparam logic [4:0] OP_BRANCH     = 5'b11000;
    localparam int         DEPTH_DEF     = 4;
    localparam int         FLUSH_CYC_DEF = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic        predict;
        logic [31:0] pred_target;
    } br_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/br_fifo.sv
// Synchronous FIFO holding in-flight branch entries in program order.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous flush of all entries (wins over push/pop)
//   push, din    : write din at the tail
//   pop          : drop the head entry
//   dout         : head entry (combinational, valid when !empty)
//   full, empty  : occupancy flags
//   count        : current number of entries
// Push while full is only legal together with a pop; the caller guarantees it.
module br_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller between the IF stage (predictor + PC mux)
// and the EX branch unit of a 5-stage RISC-V pipeline.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_valid/if_is_branch/if_pc/if_predict/if_pred_target : IF-side branch info
//   ex_valid/ex_is_branch/ex_taken/ex_target              : EX-side resolution
//   stall_if                     : queue full and no pop this cycle
//   pred_btype, pred_taken       : one-cycle predictor training pulse
//   flush                        : squash younger instructions (FLUSH_CYC cycles)
//   redirect_valid, redirect_pc  : one-cycle PC redirect
//   occupancy                    : in-flight branch count
//   branch_cnt, mispredict_cnt   : saturating statistics
//   err_underflow                : sticky, EX resolved a branch with no entry
//
// Queue handshake: an IF branch is accepted (pushed) in a cycle when it is
// valid, the FSM is in RUN, and the queue has room or the head is popped in
// the same cycle; otherwise stall_if holds it. An EX branch is consumed
// (popped) in a cycle when it is valid, the FSM is in RUN and the queue is
// non-empty. Both transfers complete at the rising clock edge.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic                       if_is_branch,
    input  logic [31:0]                if_pc,
    input  logic                       if_predict,
    input  logic [31:0]                if_pred_target,
    input  logic                       ex_valid,
    input  logic                       ex_is_branch,
    input  logic                       ex_taken,
    input  logic [31:0]                ex_target,
    output logic                       stall_if,
    output logic                       pred_btype,
    output logic                       pred_taken,
    output logic                       flush,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_cnt,
    output logic [CNT_W-1:0]           mispredict_cnt,
    output logic                       err_underflow
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    ctrl_state_t state, state_next;
    logic [FC_W-1:0] flush_cnt, flush_cnt_next;

    br_entry_t   head;
    br_entry_t   new_entry;
    logic        full, empty;
    logic        in_run;
    logic        resolve_req;
    logic        push, pop, mispredict;
    logic [31:0] act_next, pred_next;

    assign in_run      = (state == RUN);
    assign resolve_req = ex_valid & ex_is_branch;
    assign pop         = resolve_req & in_run & ~empty;

    assign act_next    = ex_taken     ? ex_target        : head.pc + 32'd4;
    assign pred_next   = head.predict ? head.pred_target : head.pc + 32'd4;
    // Compare next-PCs, so a taken prediction with a wrong target also counts.
    assign mispredict  = pop & (act_next != pred_next);

    // A push alongside a mispredicting pop is wrong-path and is dropped.
    assign push        = if_valid & if_is_branch & in_run & (~full | pop) & ~mispredict;
    assign stall_if    = in_run & full & ~pop;
    assign flush       = (state == FLUSH);

    assign new_entry.pc          = if_pc;
    assign new_entry.predict     = if_predict;
    assign new_entry.pred_target = if_pred_target;

    br_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(br_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (mispredict),
        .push  (push),
        .din   (new_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) state_next = RUN;
                else                 flush_cnt_next = flush_cnt - FC_W'(1);
            end
            default: state_next = RUN;
        endcase
    end

    // Registered resolution outputs and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_btype     <= 1'b0;
            pred_taken     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            err_underflow  <= 1'b0;
        end else begin
            pred_btype     <= pop;
            pred_taken     <= pop & ex_taken;
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= act_next;
            if (pop && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            if (resolve_req && in_run && empty)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_is_branch;
    logic [31:0] if_pc;
    logic        if_predict;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        stall_if;
    logic        pred_btype;
    logic        pred_taken;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;
    logic        err_underflow;

    int total;
    int bad;

    branch_resolve_ctrl #(
        .DEPTH     (4),
        .FLUSH_CYC (2),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_is_branch   (if_is_branch),
        .if_pc          (if_pc),
        .if_predict     (if_predict),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .stall_if       (stall_if),
        .pred_btype     (pred_btype),
        .pred_taken     (pred_taken),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt),
        .err_underflow  (err_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_valid       = 1'b0;
        if_is_branch   = 1'b0;
        if_pc          = 32'h0;
        if_predict     = 1'b0;
        if_pred_target = 32'h0;
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = 32'h0;
    endtask

    task automatic drive_if(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        if_valid       = 1'b1;
        if_is_branch   = 1'b1;
        if_pc          = pc;
        if_predict     = pred;
        if_pred_target = tgt;
    endtask

    task automatic drive_ex(input logic taken, input logic [31:0] tgt);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken     = taken;
        ex_target    = tgt;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        drive_if(pc, pred, tgt);
        step();
        if_valid     = 1'b0;
        if_is_branch = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if ({stall_if, pred_btype, pred_taken, flush, redirect_valid, err_underflow} !== 6'b0) begin
            $display("FAIL reset_flags got=%b exp=000000",
                     {stall_if, pred_btype, pred_taken, flush, redirect_valid, err_underflow});
            bad++;
        end
        total++;
        if (redirect_pc !== 32'h0 || occupancy !== 3'd0) begin
            $display("FAIL reset_pc_occ got pc=%h occ=%0d exp pc=0 occ=0", redirect_pc, occupancy);
            bad++;
        end
        total++;
        if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL reset_cnt got br=%0d mis=%0d exp 0 0", branch_cnt, mispredict_cnt);
            bad++;
        end
    endtask

    task automatic test_correct_taken();
        push_one(32'h100, 1'b1, 32'h80);
        total++;
        if (occupancy !== 3'd1) begin
            $display("FAIL ct_occ_push got=%0d exp=1", occupancy);
            bad++;
        end
        drive_ex(1'b1, 32'h80);
        step();
        ex_valid = 1'b0;
        total++;
        if ({pred_btype, pred_taken, redirect_valid, flush} !== 4'b1100) begin
            $display("FAIL ct_train got=%b exp=1100", {pred_btype, pred_taken, redirect_valid, flush});
            bad++;
        end
        total++;
        if (branch_cnt !== 16'd1 || mispredict_cnt !== 16'd0 || occupancy !== 3'd0) begin
            $display("FAIL ct_cnt got br=%0d mis=%0d occ=%0d exp 1 0 0", branch_cnt, mispredict_cnt, occupancy);
            bad++;
        end
        step();
        total++;
        if (pred_btype !== 1'b0) begin
            $display("FAIL ct_pulse got=%b exp=0", pred_btype);
            bad++;
        end
    endtask

    task automatic test_mispredict();
        push_one(32'h200, 1'b0, 32'h210);
        // resolve taken to 0x240 while IF offers a wrong-path branch
        drive_ex(1'b1, 32'h240);
        drive_if(32'h204, 1'b0, 32'h0);
        step();
        ex_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin
            $display("FAIL mp_redirect got v=%b pc=%h exp v=1 pc=240", redirect_valid, redirect_pc);
            bad++;
        end
        total++;
        if (flush !== 1'b1 || occupancy !== 3'd0 || mispredict_cnt !== 16'd1 || branch_cnt !== 16'd2) begin
            $display("FAIL mp_state got fl=%b occ=%0d mis=%0d br=%0d exp 1 0 1 2",
                     flush, occupancy, mispredict_cnt, branch_cnt);
            bad++;
        end
        total++;
        if (pred_taken !== 1'b1 || stall_if !== 1'b0) begin
            $display("FAIL mp_taken got pt=%b st=%b exp 1 0", pred_taken, stall_if);
            bad++;
        end
        // IF keeps offering during flush; must be ignored
        step();
        total++;
        if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
            $display("FAIL mp_flush2 got fl=%b rv=%b exp 1 0", flush, redirect_valid);
            bad++;
        end
        step();
        if_valid = 1'b0;
        total++;
        if (flush !== 1'b0 || occupancy !== 3'd0) begin
            $display("FAIL mp_flush_end got fl=%b occ=%0d exp 0 0", flush, occupancy);
            bad++;
        end
    endtask

    task automatic test_wrong_target();
        push_one(32'h300, 1'b1, 32'h340);
        drive_ex(1'b1, 32'h380);
        step();
        ex_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h380 || mispredict_cnt !== 16'd2) begin
            $display("FAIL wt_taken got v=%b pc=%h mis=%0d exp 1 380 2", redirect_valid, redirect_pc, mispredict_cnt);
            bad++;
        end
        step();
        step();
        push_one(32'h300, 1'b1, 32'h340);
        drive_ex(1'b0, 32'h340);
        step();
        ex_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || pred_taken !== 1'b0) begin
            $display("FAIL wt_nottaken got v=%b pc=%h pt=%b exp 1 304 0", redirect_valid, redirect_pc, pred_taken);
            bad++;
        end
        step();
        step();
        // correctly predicted not-taken
        push_one(32'h400, 1'b0, 32'h500);
        drive_ex(1'b0, 32'h500);
        step();
        ex_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || branch_cnt !== 16'd5 || mispredict_cnt !== 16'd3) begin
            $display("FAIL wt_correct_nt got rv=%b fl=%b br=%0d mis=%0d exp 0 0 5 3",
                     redirect_valid, flush, branch_cnt, mispredict_cnt);
            bad++;
        end
        // pc+4 wraps to 0 and matches a taken-to-0 prediction
        push_one(32'hFFFF_FFFC, 1'b1, 32'h0);
        drive_ex(1'b0, 32'h1234);
        step();
        ex_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b0 || branch_cnt !== 16'd6 || mispredict_cnt !== 16'd3) begin
            $display("FAIL wt_wrap got rv=%b br=%0d mis=%0d exp 0 6 3", redirect_valid, branch_cnt, mispredict_cnt);
            bad++;
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(i * 4), 1'b0, 32'h0);
        total++;
        if (occupancy !== 3'd4) begin
            $display("FAIL full_occ got=%0d exp=4", occupancy);
            bad++;
        end
        drive_if(32'h510, 1'b1, 32'h600);
        #1;
        total++;
        if (stall_if !== 1'b1) begin
            $display("FAIL full_stall got=%b exp=1", stall_if);
            bad++;
        end
        step();
        total++;
        if (occupancy !== 3'd4) begin
            $display("FAIL full_no_push got=%0d exp=4", occupancy);
            bad++;
        end
        // same branch again, now with a correct pop of head 0x500
        drive_ex(1'b0, 32'h0);
        #1;
        total++;
        if (stall_if !== 1'b0) begin
            $display("FAIL full_pop_stall got=%b exp=0", stall_if);
            bad++;
        end
        step();
        if_valid = 1'b0;
        total++;
        if (occupancy !== 3'd4 || pred_btype !== 1'b1 || redirect_valid !== 1'b0) begin
            $display("FAIL full_pushpop got occ=%0d bt=%b rv=%b exp 4 1 0", occupancy, pred_btype, redirect_valid);
            bad++;
        end
        // drain in order: 0x504, 0x508, 0x50c not taken, then 0x510 taken to 0x600
        for (int i = 0; i < 3; i++) step();
        drive_ex(1'b1, 32'h600);
        step();
        ex_valid = 1'b0;
        total++;
        if (occupancy !== 3'd0 || branch_cnt !== 16'd11 || mispredict_cnt !== 16'd3 || flush !== 1'b0) begin
            $display("FAIL full_drain got occ=%0d br=%0d mis=%0d fl=%b exp 0 11 3 0",
                     occupancy, branch_cnt, mispredict_cnt, flush);
            bad++;
        end
    endtask

    task automatic test_underflow();
        drive_ex(1'b1, 32'h0);
        step();
        ex_valid = 1'b0;
        total++;
        if (err_underflow !== 1'b1 || pred_btype !== 1'b0 || flush !== 1'b0 || branch_cnt !== 16'd11) begin
            $display("FAIL uf_set got err=%b bt=%b fl=%b br=%0d exp 1 0 0 11",
                     err_underflow, pred_btype, flush, branch_cnt);
            bad++;
        end
        step();
        step();
        total++;
        if (err_underflow !== 1'b1) begin
            $display("FAIL uf_sticky got=%b exp=1", err_underflow);
            bad++;
        end
    endtask

    task automatic test_reset_in_flush();
        push_one(32'h700, 1'b0, 32'h0);
        drive_ex(1'b1, 32'h740);
        step();
        ex_valid = 1'b0;
        total++;
        if (flush !== 1'b1) begin
            $display("FAIL rf_enter got=%b exp=1", flush);
            bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (flush !== 1'b0 || err_underflow !== 1'b0 || redirect_pc !== 32'h0 || occupancy !== 3'd0) begin
            $display("FAIL rf_abort got fl=%b err=%b pc=%h occ=%0d exp 0 0 0 0",
                     flush, err_underflow, redirect_pc, occupancy);
            bad++;
        end
        total++;
        if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL rf_cnt got br=%0d mis=%0d exp 0 0", branch_cnt, mispredict_cnt);
            bad++;
        end
        step();
        total++;
        if (flush !== 1'b0) begin
            $display("FAIL rf_stay got=%b exp=0", flush);
            bad++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_idle();
        test_reset();
        test_correct_taken();
        test_mispredict();
        test_wrong_target();
        test_full();
        test_underflow();
        test_reset_in_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor in the 5-stage RISC-V pipeline.
- Records every branch the IF stage predicts in an in-order queue and retires each entry when EX resolves the branch.
- On a misprediction it drives the predictor's training inputs (btype/taken), raises the pipeline flush, and issues the redirect PC.
- Sits between the IF stage (predictor + PC mux) and the EX branch unit.

Parameters:
- DEPTH, 4, in-flight branch queue entries; power of two, ≥2.
- FLUSH_CYC, 2, cycles flush stays asserted after a mispredict; ≥1.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  IF stage holds a valid instruction this cycle.
- if_is_branch  in  1  IF instruction is B-type (opcode[6:2]=11000).
- if_pc  in  32  PC of the IF instruction.
- if_predict  in  1  predictor output (1 = taken).
- if_pred_target  in  32  PC+B-immediate computed in IF.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  EX instruction is B-type.
- ex_taken  in  1  resolved branch outcome.
- ex_target  in  32  resolved branch target.
- stall_if  out  1  hold IF: queue full and no pop this cycle.
- pred_btype  out  1  one-cycle training pulse to the predictor.
- pred_taken  out  1  outcome qualified by pred_btype.
- flush  out  1  squash IF/ID/EX-younger instructions.
- redirect_valid  out  1  one-cycle pulse; load redirect_pc into the PC.
- redirect_pc  out  32  corrected fetch address.
- occupancy  out  log2(DEPTH)+1  current queue entries.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispredict_cnt  out  CNT_W  mispredicts, saturating.
- err_underflow  out  1  sticky: EX resolved a branch with the queue empty.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Queue empties; FSM goes to RUN.
  - All outputs 0 except redirect_pc=32'h0 and occupancy=0.
  - Counters clear; err_underflow clears.
  - Reset mid-flush aborts the flush immediately.
- Queue entry: {pc[31:0], predict, pred_target[31:0]}; FIFO order; pointers wrap modulo DEPTH.
- Push = if_valid & if_is_branch & state==RUN & (!full | pop).
  - If full and no pop, stall_if=1 combinationally and the entry is not pushed.
  - Push and pop in the same cycle while full are legal; occupancy is unchanged.
- Pop = ex_valid & ex_is_branch & state==RUN & !empty. The popped entry is the head.
- Resolution (combinational on the pop cycle):
  - act_next = ex_taken ? ex_target : pc+4.
  - pred_next = predict ? pred_target : pc+4.
  - All adds are 32-bit and wrap modulo 2^32.
  - mispredict = act_next != pred_next. A predicted-taken branch with the wrong target counts as a mispredict.
- Registered outputs, valid the cycle after pop (latency 1):
  - pred_btype=1 and pred_taken=ex_taken for every pop.
  - branch_cnt+1 for every pop.
  - On mispredict additionally: redirect_valid=1, redirect_pc=act_next, mispredict_cnt+1, FSM→FLUSH.
- Empty-queue resolve (EX branch with the queue empty):
  - err_underflow set (sticky until rst).
  - No training pulse, no flush, counters unchanged.
- FSM:
  - RUN: normal push/pop.
  - RUN→FLUSH on a registered mispredict. Entering FLUSH clears the queue (younger branches are squashed) and loads the flush counter with FLUSH_CYC-1.
  - FLUSH: flush=1; pushes and pops are ignored; the counter decrements each cycle.
  - FLUSH→RUN when the counter reaches 0. flush is therefore high for exactly FLUSH_CYC cycles.
- A push coincident with the mispredicting pop is discarded. The entry would be a wrong-path branch.
- stall_if=0 in FLUSH. IF is being redirected, so no stall is needed.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package branch_ctrl_pkg holds:
  - the br_entry_t struct (pc, predict, pred_target);
  - the ctrl_state_t enum {RUN, FLUSH};
  - the RV opcode constant OP_BRANCH=5'b11000;
  - defaults DEPTH_DEF=4, FLUSH_CYC_DEF=2.
- One sub-module, br_fifo: parameterised synchronous FIFO with push, pop, clear, full, empty and count.
- The top level holds compare logic, the FSM, and the counters.

Test Plan:
- Reset then idle → all outputs 0, occupancy=0, stall_if=0.
- Push pc=0x100, predict=1, target=0x80; resolve ex_taken=1, ex_target=0x80 → next cycle pred_btype=1, pred_taken=1, no redirect, branch_cnt=1.
- Push pc=0x200, predict=0; resolve taken to 0x240 → next cycle redirect_valid=1, redirect_pc=0x240, flush high 2 cycles, occupancy=0, mispredict_cnt=1.
- Mispredict with wrong target: push pc=0x300, predict=1, target=0x340; resolve taken to 0x380 → redirect_pc=0x380. Resolve not-taken instead → redirect_pc=0x304.
- Fill 4 entries; 5th branch with no pop → stall_if=1 and occupancy stays 4. Same cycle with pop → pushed, occupancy=4, stall_if=0.
- EX branch with the queue empty → err_underflow=1 and stays high. rst during FLUSH → flush=0 the next cycle.
